// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants, FSM state type and the double-dabble step
//               used by the BCD converter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int DATA_W_DEF = 20;  // default binary operand width
  localparam int BCD_W      = 24;  // six output BCD digits
  localparam int BCD_ACC_W  = 28;  // seven-digit internal accumulator
  localparam int N_ITER     = 20;  // one iteration per operand bit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One double-dabble iteration: correct every digit >= 5 by +3, then shift
  // the accumulator left by one, bringing in the next operand bit.
  function automatic logic [BCD_ACC_W-1:0] dabble_step(
    input logic [BCD_ACC_W-1:0] acc,
    input logic                 bit_in
  );
    logic [BCD_ACC_W-1:0] adj;
    adj = acc;
    for (int d = 0; d < BCD_ACC_W / 4; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
    end
    return {adj[BCD_ACC_W-2:0], bit_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : bcd_iter_core
// Description : Iterative binary-to-BCD converter (double dabble). A start
//               pulse latches the operand; N_ITER iterations follow, one per
//               clock. During the final iteration 'done' is high and 'bcd'
//               carries the completed result combinationally, so the caller
//               can register it on the same edge that ends the conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_iter_core #(
  parameter int DATA_W = bcd_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] operand,
  output logic              done,
  output logic [27:0]       bcd
);
  import bcd_pkg::*;

  localparam int CNT_W = $clog2(N_ITER);

  logic [N_ITER-1:0]    r_shreg;
  logic [BCD_ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_run;
  logic [BCD_ACC_W-1:0] w_acc_nxt;
  logic                 w_last;

  assign w_acc_nxt = dabble_step(r_acc, r_shreg[N_ITER-1]);
  assign w_last    = r_run && (r_cnt == CNT_W'(N_ITER - 1));
  assign done      = w_last;
  assign bcd       = w_acc_nxt;

  // Load on start, then iterate MSB-first until the last step completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (start) begin
      r_shreg <= N_ITER'(operand);
      r_acc   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_acc   <= w_acc_nxt;
      r_shreg <= r_shreg << 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_arbiter
// Description : Round-robin arbiter sharing one iterative binary-to-BCD
//               converter among N_REQ requesters. IDLE -> CONV (20 cycles)
//               -> DONE (one-cycle ack) -> IDLE.
//               Optional macro BCD_ARB_SAT_EN: operands above 999999
//               saturate dcm to 0x999999 and raise ovf; otherwise dcm is the
//               low six digits and ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = bcd_pkg::DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    bny,
  output logic [N_REQ-1:0]           ack,
  output logic [23:0]                dcm,
  output logic                       ovf,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);
  import bcd_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_grant;
  logic [ID_W-1:0]      w_win;
  logic [DATA_W-1:0]    w_sel_opnd;
  logic                 w_capture;
  logic                 w_finish;
  logic                 w_core_done;
  logic [BCD_ACC_W-1:0] w_core_bcd;
  logic [BCD_W-1:0]     r_dcm;
  logic [BCD_W-1:0]     w_dcm_nxt;

  // First active requester in the order p, p+1, ..., wrapping.
  function automatic logic [ID_W-1:0] f_rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [ID_W-1:0]  p
  );
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    int              k;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(p) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      idx = ID_W'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

  // Arbitration winner and its operand slice.
  always_comb begin
    w_win      = f_rr_pick(req, r_ptr);
    w_sel_opnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_sel_opnd = bny[i*DATA_W +: DATA_W];
      end
    end
  end

  bcd_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .start   (w_capture),
    .operand (w_sel_opnd),
    .done    (w_core_done),
    .bcd     (w_core_bcd)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, capture/finish strobes, busy and ack.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    busy        = 1'b0;
    ack         = '0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_capture   = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (w_core_done) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        ack[r_grant] = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant index and round-robin pointer advance at capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_grant <= '0;
    end else if (w_capture) begin
      r_grant <= w_win;
      r_ptr   <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
    end
  end

`ifdef BCD_ARB_SAT_EN
  logic r_ovf;
  logic w_ovf_nxt;

  assign w_ovf_nxt = |w_core_bcd[BCD_ACC_W-1:BCD_W];
  assign w_dcm_nxt = w_ovf_nxt ? 24'h999999 : w_core_bcd[BCD_W-1:0];
  assign ovf       = r_ovf;

  // Overflow flag is registered alongside the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_finish) begin
      r_ovf <= w_ovf_nxt;
    end
  end
`else
  // Seventh digit is discarded: the result wraps modulo 1000000.
  logic w_unused_hi;

  assign w_unused_hi = ^w_core_bcd[BCD_ACC_W-1:BCD_W];
  assign w_dcm_nxt   = w_core_bcd[BCD_W-1:0];
  assign ovf         = 1'b0;
`endif

  // Result register, updated only when a conversion completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dcm <= '0;
    end else if (w_finish) begin
      r_dcm <= w_dcm_nxt;
    end
  end

  assign dcm      = r_dcm;
  assign grant_id = r_grant;

endmodule
`default_nettype wire
